radarscp_grid_sweep: RTL and testbench
======================================

RADARSCP_GRID_SWEEP -- requirements
Module: radarscp_grid_sweep

Interface
REQ-001 CLK_24M  input  1  system clock; all state changes on its rising edge.
REQ-002 RESETn  input  1  asynchronous, active-low reset.
REQ-003 CLK_EN  input  1  pixel clock enable; state advances only on cycles where CLK_EN=1.
REQ-004 I_VBLKn  input  1  vertical blank, active low; frame-start strobe is its 1->0 transition, sampled on CLK_EN cycles.
REQ-005 I_V_CNT  input  8  current video line, 0..255.
REQ-006 I_DISPLAY  input  1  raw grid pixel from the grid/star generator.
REQ-007 I_GRID_EN  input  1  CPU grid-enable latch; 1 = grid requested.
REQ-008 I_RATE  input  4  frames per reveal step, minus 1; 0 = step every frame.
REQ-009 I_FLIPn  input  1  0 = screen flipped; the reveal starts from the bottom line.
REQ-010 O_DISPLAY  output  1  gated grid pixel.
REQ-011 O_BUSY  output  1  1 while in SWEEP or COLLAPSE.
REQ-012 O_STATE  output  2  state encoding: IDLE=0, SWEEP=1, FULL=2, COLLAPSE=3.

Function
REQ-013 Registers SHALL be: STATE (2b), REVEAL (9b, range 0..256), FCNT (4b), VBLK_D (1b, previous sampled I_VBLKn).
REQ-014 FS (frame start) SHALL be 1 on a CLK_EN cycle where VBLK_D=1 and I_VBLKn=0; VBLK_D<=I_VBLKn on every CLK_EN cycle.
REQ-015 STATE, REVEAL and FCNT SHALL change only on FS cycles; I_GRID_EN and I_RATE SHALL be sampled only on FS.
REQ-016 On FS in IDLE with I_GRID_EN=1, the block SHALL go to SWEEP, set REVEAL=0 and set FCNT=0.
REQ-017 On FS in SWEEP with I_GRID_EN=1, if FCNT==I_RATE then FCNT<=0 and REVEAL<=REVEAL+8; otherwise FCNT<=FCNT+1.
REQ-018 If a SWEEP step brings REVEAL to 256, STATE SHALL become FULL in the same FS cycle.
REQ-019 On FS in SWEEP or FULL with I_GRID_EN=0, the block SHALL go to COLLAPSE with FCNT=0 and REVEAL unchanged; FULL enters COLLAPSE with REVEAL=256.
REQ-020 On FS in COLLAPSE with I_GRID_EN=0, a step (FCNT==I_RATE) SHALL set REVEAL<=REVEAL-8; if the result is 0, STATE SHALL become IDLE.
REQ-021 On FS in COLLAPSE with I_GRID_EN=1, the block SHALL go to SWEEP with FCNT=0 and REVEAL unchanged (reverse mid-collapse, no restart from 0).
REQ-022 A change of I_RATE mid-sweep SHALL take effect at the next FS compare.
REQ-023 If FCNT>I_RATE after a rate decrease, FCNT SHALL wrap through 15 to 0 with no forced step.
REQ-024 With REVEAL a multiple of 8, REVEAL SHALL never underflow below 0 or exceed 256.
REQ-025 Line index L SHALL be I_V_CNT when I_FLIPn=1, and 255-I_V_CNT when I_FLIPn=0.
REQ-026 GATE SHALL be 1 in FULL, 0 in IDLE, and (L < REVEAL) in SWEEP and COLLAPSE.
REQ-027 O_DISPLAY SHALL be I_DISPLAY AND GATE, combinational, with zero latency from I_DISPLAY, I_V_CNT and I_FLIPn.
REQ-028 O_BUSY SHALL be (STATE==SWEEP or STATE==COLLAPSE); O_STATE SHALL be registered state.
REQ-029 An FS cycle with CLK_EN=0 SHALL not be possible by construction; an I_VBLKn edge between CLK_EN cycles SHALL be detected on the next CLK_EN cycle.

Reset
REQ-030 On RESETn=0, immediately and asynchronously: STATE=IDLE, REVEAL=0, FCNT=0, VBLK_D=1.
REQ-031 During reset, O_DISPLAY=0, O_BUSY=0 and O_STATE=0.
REQ-032 Reset asserted mid-SWEEP or mid-COLLAPSE SHALL abort to IDLE; after release, the first FS is not lost if I_VBLKn is still 1.

Verification
REQ-033 I_GRID_EN=1, I_RATE=0, I_FLIPn=1, 33 frames -> SWEEP after FS1; REVEAL=8 after FS2; FULL after FS33 (REVEAL=256); O_BUSY 1->0.
REQ-034 SWEEP with REVEAL=64, I_DISPLAY=1 -> O_DISPLAY=1 for I_V_CNT 0..63 and 0 at 64; with I_FLIPn=0, O_DISPLAY=1 for I_V_CNT 192..255 only.
REQ-035 I_RATE=3 -> REVEAL increments by 8 every 4th FS; FCNT sequence 0,1,2,3,0.
REQ-036 FULL, then I_GRID_EN=0, I_RATE=0 -> COLLAPSE on the next FS; REVEAL 256->248 on the following FS; IDLE after 32 steps, with O_DISPLAY=0 throughout IDLE.
REQ-037 COLLAPSE at REVEAL=120, then I_GRID_EN=1 -> SWEEP on the next FS with REVEAL=120; the next step gives 128.
REQ-038 RESETn pulsed low mid-SWEEP (REVEAL=40) -> O_STATE=0, O_DISPLAY=0 immediately; with I_GRID_EN=1, a fresh sweep starts from REVEAL=0 on the first FS after release.

Source files
------------

// File: rtl/radarscp_grid_sweep.sv
// Radar-scope grid reveal: sweeps the star/grid field open line by line
// on frame starts, holds it fully open, and collapses it when disabled.
module radarscp_grid_sweep (
  input  logic       CLK_24M,
  input  logic       RESETn,
  input  logic       CLK_EN,
  input  logic       I_VBLKn,
  input  logic [7:0] I_V_CNT,
  input  logic       I_DISPLAY,
  input  logic       I_GRID_EN,
  input  logic [3:0] I_RATE,
  input  logic       I_FLIPn,
  output logic       O_DISPLAY,
  output logic       O_BUSY,
  output logic [1:0] O_STATE
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_COLL  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [8:0] reveal;
  logic [8:0] reveal_nx;
  logic [3:0] fcnt;
  logic [3:0] fcnt_nx;
  logic       vblk_d;
  logic       fs;
  logic       step;
  logic [7:0] line;
  logic       gate;

  assign fs   = CLK_EN & vblk_d & ~I_VBLKn;
  assign step = (fcnt == I_RATE);

  always_comb begin
    state_nx  = state;
    reveal_nx = reveal;
    fcnt_nx   = fcnt;
    unique case (state)
      ST_IDLE: begin
        if (I_GRID_EN) begin
          state_nx  = ST_SWEEP;
          reveal_nx = 9'd0;
          fcnt_nx   = 4'd0;
        end
      end
      ST_SWEEP: begin
        if (!I_GRID_EN) begin
          state_nx = ST_COLL;
          fcnt_nx  = 4'd0;
        end else if (step) begin
          fcnt_nx   = 4'd0;
          reveal_nx = reveal + 9'd8;
          if (reveal >= 9'd248) begin
            reveal_nx = 9'd256;
            state_nx  = ST_FULL;
          end
        end else begin
          fcnt_nx = fcnt + 4'd1;
        end
      end
      ST_FULL: begin
        if (!I_GRID_EN) begin
          state_nx  = ST_COLL;
          reveal_nx = 9'd256;
          fcnt_nx   = 4'd0;
        end
      end
      ST_COLL: begin
        if (I_GRID_EN) begin
          state_nx = ST_SWEEP;
          fcnt_nx  = 4'd0;
        end else if (step) begin
          fcnt_nx = 4'd0;
          // clamp so a collapse entered at 0 cannot wrap
          if (reveal <= 9'd8) begin
            reveal_nx = 9'd0;
            state_nx  = ST_IDLE;
          end else begin
            reveal_nx = reveal - 9'd8;
          end
        end else begin
          fcnt_nx = fcnt + 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge RESETn) begin
    if (!RESETn) begin
      state  <= ST_IDLE;
      reveal <= 9'd0;
      fcnt   <= 4'd0;
      vblk_d <= 1'b1;
    end else begin
      if (CLK_EN) vblk_d <= I_VBLKn;
      if (fs) begin
        state  <= state_nx;
        reveal <= reveal_nx;
        fcnt   <= fcnt_nx;
      end
    end
  end

  assign line = I_FLIPn ? I_V_CNT : (8'd255 - I_V_CNT);

  always_comb begin
    gate = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): gate = 1'b0;
      (state == ST_FULL): gate = 1'b1;
      default:            gate = ({1'b0, line} < reveal);
    endcase
  end

  assign O_DISPLAY = I_DISPLAY & gate;
  assign O_BUSY    = (state == ST_SWEEP) | (state == ST_COLL);
  assign O_STATE   = state;

endmodule

// File: tb/tb_radarscp_grid_sweep.sv
// Bench for radarscp_grid_sweep: directed frames plus random frames,
// checked against a frame-level model of the reveal window.
module tb_radarscp_grid_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       vblk_n = 1'b1;
  logic [7:0] v_cnt = 8'd0;
  logic       disp_in = 1'b0;
  logic       grid_en = 1'b0;
  logic [3:0] rate = 4'd0;
  logic       flip_n = 1'b1;
  logic       disp_out;
  logic       busy;
  logic [1:0] st;

  int n_assert = 0;
  int n_fail = 0;

  // model: 0 idle, 1 sweep, 2 full, 3 collapse
  int m_state = 0;
  int m_reveal = 0;
  int m_fcnt = 0;

  radarscp_grid_sweep dut (
    .CLK_24M   (clk),
    .RESETn    (rst_n),
    .CLK_EN    (clk_en),
    .I_VBLKn   (vblk_n),
    .I_V_CNT   (v_cnt),
    .I_DISPLAY (disp_in),
    .I_GRID_EN (grid_en),
    .I_RATE    (rate),
    .I_FLIPn   (flip_n),
    .O_DISPLAY (disp_out),
    .O_BUSY    (busy),
    .O_STATE   (st)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_gate(input int l);
    if (m_state == 2) return 1;
    if (m_state == 0) return 0;
    return (l < m_reveal) ? 1 : 0;
  endfunction

  task automatic model_fs();
    int ge;
    int r;
    ge = int'(grid_en);
    r = int'(rate);
    case (m_state)
      0: if (ge == 1) begin
        m_state = 1; m_reveal = 0; m_fcnt = 0;
      end
      1: if (ge == 0) begin
        m_state = 3; m_fcnt = 0;
      end else if (m_fcnt == r) begin
        m_fcnt = 0;
        m_reveal = m_reveal + 8;
        if (m_reveal >= 256) begin
          m_reveal = 256; m_state = 2;
        end
      end else m_fcnt = (m_fcnt + 1) % 16;
      2: if (ge == 0) begin
        m_state = 3; m_fcnt = 0;
      end
      default: if (ge == 1) begin
        m_state = 1; m_fcnt = 0;
      end else if (m_fcnt == r) begin
        m_fcnt = 0;
        m_reveal = (m_reveal > 8) ? m_reveal - 8 : 0;
        if (m_reveal == 0) m_state = 0;
      end else m_fcnt = (m_fcnt + 1) % 16;
    endcase
  endtask

  // one vertical-blank fall; optional enable gap around the edge
  task automatic frame(input bit gap);
    @(negedge clk);
    vblk_n = 1'b0;
    clk_en = gap ? 1'b0 : 1'b1;
    if (gap) begin
      @(negedge clk);
      @(negedge clk);
      clk_en = 1'b1;
    end
    @(negedge clk);
    vblk_n = 1'b1;
    @(negedge clk);
    model_fs();
  endtask

  task automatic check_all(input string tag);
    int ls[3];
    bit f;
    @(negedge clk);
    #1;
    chk({tag, ":state"}, int'(st), m_state);
    chk({tag, ":busy"}, int'(busy), (m_state == 1 || m_state == 3) ? 1 : 0);
    ls[0] = m_reveal - 1;
    ls[1] = m_reveal;
    ls[2] = $urandom_range(0, 255);
    for (int i = 0; i < 3; i++) begin
      if (ls[i] >= 0 && ls[i] <= 255) begin
        f = 1'($urandom_range(0, 1));
        flip_n = f;
        v_cnt = f ? 8'(ls[i]) : 8'(255 - ls[i]);
        disp_in = 1'b1;
        #1;
        chk({tag, ":disp"}, int'(disp_out), exp_gate(ls[i]));
        disp_in = 1'b0;
        #1;
        chk({tag, ":disp0"}, int'(disp_out), 0);
      end
    end
  endtask

  task automatic scan_lines(input string tag);
    int l;
    disp_in = 1'b1;
    for (int f = 0; f < 2; f++) begin
      flip_n = 1'(f);
      for (int v = 0; v < 256; v++) begin
        v_cnt = 8'(v);
        l = (f == 1) ? v : 255 - v;
        #1;
        chk({tag, ":scan"}, int'(disp_out), exp_gate(l));
      end
    end
    disp_in = 1'b0;
    flip_n = 1'b1;
  endtask

  initial begin
    disp_in = 1'b1;
    #5;
    chk("rst:state", int'(st), 0);
    chk("rst:busy", int'(busy), 0);
    chk("rst:disp", int'(disp_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    disp_in = 1'b0;

    // full sweep at one step per frame
    grid_en = 1'b1;
    rate = 4'd0;
    for (int i = 0; i < 33; i++) begin
      frame(1'b0);
      check_all("sweep");
      if (m_reveal == 64 && m_state == 1) scan_lines("r64");
    end
    chk("full:state", int'(st), 2);

    // full collapse back to idle
    grid_en = 1'b0;
    for (int i = 0; i < 33; i++) begin
      frame(1'b0);
      check_all("coll");
    end
    frame(1'b0);
    check_all("coll_end");
    chk("idle:state", int'(st), 0);

    // slow rate: one step every fourth frame
    grid_en = 1'b1;
    rate = 4'd3;
    for (int i = 0; i < 9; i++) begin
      frame(i[0]);
      check_all("rate3");
    end

    // rate decrease with counter past the new rate
    rate = 4'd5;
    for (int i = 0; i < 4; i++) begin
      frame(1'b0);
      check_all("rate5");
    end
    rate = 4'd1;
    for (int i = 0; i < 16; i++) begin
      frame(1'b0);
      check_all("ratewrap");
    end

    // reverse mid-collapse
    rate = 4'd0;
    while (m_reveal < 128 && m_state == 1) begin
      frame(1'b0);
      check_all("to128");
    end
    grid_en = 1'b0;
    frame(1'b0);
    check_all("rev_coll");
    while (m_reveal > 120) begin
      frame(1'b0);
      check_all("rev_down");
    end
    grid_en = 1'b1;
    frame(1'b0);
    check_all("rev_sweep");
    frame(1'b0);
    check_all("rev_step");

    // random frames
    for (int i = 0; i < 300; i++) begin
      grid_en = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      rate = 4'($urandom_range(0, 3));
      frame(1'($urandom_range(0, 1)));
      check_all("rand");
    end

    // reset mid-sweep, then restart
    grid_en = 1'b0;
    while (m_state != 0) begin
      frame(1'b0);
      check_all("drain");
    end
    grid_en = 1'b1;
    rate = 4'd0;
    for (int i = 0; i < 6; i++) begin
      frame(1'b0);
      check_all("pre_rst");
    end
    @(negedge clk);
    #3;
    flip_n = 1'b1;
    v_cnt = 8'd0;
    disp_in = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst:state", int'(st), 0);
    chk("arst:busy", int'(busy), 0);
    chk("arst:disp", int'(disp_out), 0);
    m_state = 0;
    m_reveal = 0;
    m_fcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b0);
    check_all("post_rst");
    frame(1'b0);
    check_all("post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
